// File: rtl/binary_clock_pkg.sv
// Shared state encoding and default timing constants for the PPS conditioning path.
package binary_clock_pkg;

  typedef enum logic [1:0] {
    FREERUN  = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } pps_state_t;

  localparam int unsigned CLK_DIV_DEF    = 100;
  localparam int unsigned TOL_DEF        = 2;
  localparam int unsigned LOCK_COUNT_DEF = 3;
  localparam int unsigned FILT_DEF       = 2;

endpackage

// File: rtl/pps_filter.sv
// Synchronizes the raw PPS input, rejects glitches shorter than FILT cycles,
// and emits a registered one-cycle pulse on each filtered rising edge.
module pps_filter #(
  parameter int unsigned FILT = binary_clock_pkg::FILT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pps_in,
  output logic rise
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] RUN_LAST = CW'(FILT - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] run;

  // Two-flop synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pps_in;
      sync2 <= sync1;
    end
  end

  // Level follows sync2 only after FILT consecutive disagreeing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      run   <= '0;
    end else if (sync2 == level) begin
      run <= '0;
    end else if (run == RUN_LAST) begin
      level <= sync2;
      run   <= '0;
    end else begin
      run <= run + CW'(1);
    end
  end

  // Registered rising-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/pps_conditioner.sv
// Conditions an external PPS into a clean one-per-second tick, free-running
// when the reference is absent and phase-locking to it when it is present.
module pps_conditioner #(
  parameter int unsigned CLK_DIV    = binary_clock_pkg::CLK_DIV_DEF,
  parameter int unsigned TOL        = binary_clock_pkg::TOL_DEF,
  parameter int unsigned LOCK_COUNT = binary_clock_pkg::LOCK_COUNT_DEF,
  parameter int unsigned FILT       = binary_clock_pkg::FILT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pps_in,
  output logic       sec_tick,
  output logic [1:0] state,
  output logic       locked,
  output logic       miss
);

  import binary_clock_pkg::*;

  localparam int unsigned TW = $clog2(CLK_DIV + TOL + 1);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

  localparam logic [TW-1:0] T_NOM   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_EARLY = TW'(CLK_DIV - 1 - TOL);
  localparam logic [TW-1:0] T_LATE  = TW'(CLK_DIV - 1 + TOL);
  localparam logic [TW-1:0] T_HALF  = TW'(CLK_DIV / 2);
  localparam logic [GW-1:0] G_LAST  = GW'(LOCK_COUNT - 1);

  pps_state_t    cur;
  pps_state_t    nxt;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nxt;
  logic [GW-1:0] good;
  logic [GW-1:0] good_nxt;
  logic          tick_nxt;
  logic          miss_nxt;
  logic          rise;

  pps_filter #(
    .FILT(FILT)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .pps_in (pps_in),
    .rise   (rise)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= FREERUN;
      tcnt     <= '0;
      good     <= '0;
      sec_tick <= 1'b0;
      miss     <= 1'b0;
      locked   <= 1'b0;
    end else begin
      cur      <= nxt;
      tcnt     <= tcnt_nxt;
      good     <= good_nxt;
      sec_tick <= tick_nxt;
      miss     <= miss_nxt;
      locked   <= (nxt == LOCKED);
    end
  end

  assign state = cur;

  // Next-state: realign when unlocked, window-check edges when tracking
  always_comb begin
    nxt      = cur;
    tcnt_nxt = (tcnt == T_LATE) ? tcnt : tcnt + TW'(1);
    good_nxt = good;
    tick_nxt = 1'b0;
    miss_nxt = 1'b0;

    case (cur)
      FREERUN, HOLDOVER: begin
        if (rise) begin
          nxt      = ACQUIRE;
          good_nxt = '0;
          tcnt_nxt = '0;
          tick_nxt = (tcnt >= T_HALF);
        end else if (tcnt == T_NOM) begin
          tick_nxt = 1'b1;
          tcnt_nxt = '0;
        end
      end

      ACQUIRE, LOCKED: begin
        if (rise && (tcnt >= T_EARLY)) begin
          tick_nxt = 1'b1;
          tcnt_nxt = '0;
          if (cur == ACQUIRE) begin
            good_nxt = good + GW'(1);
            if (good == G_LAST) begin
              nxt = LOCKED;
            end
          end
        end else if (rise) begin
          // Early edge: lose confidence but keep counting from the last tick
          good_nxt = '0;
          nxt      = ACQUIRE;
        end else if (tcnt >= T_LATE) begin
          tick_nxt = 1'b1;
          miss_nxt = 1'b1;
          tcnt_nxt = '0;
          good_nxt = '0;
          nxt      = (cur == ACQUIRE) ? FREERUN : HOLDOVER;
        end
      end

      default: begin
        nxt = FREERUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pps_conditioner.sv
// Bench for pps_conditioner: directed and random PPS patterns against a
// tick-timestamp reference model, checked through an expected-tick queue.
module tb_pps_conditioner;

  localparam int CLK_DIV    = 100;
  localparam int TOL        = 2;
  localparam int LOCK_COUNT = 3;
  localparam int FILT       = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pps_in;
  logic       sec_tick;
  logic [1:0] state;
  logic       locked;
  logic       miss;

  pps_conditioner #(
    .CLK_DIV    (CLK_DIV),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .FILT       (FILT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pps_in   (pps_in),
    .sec_tick (sec_tick),
    .state    (state),
    .locked   (locked),
    .miss     (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int mis;
  } exp_t;

  exp_t expq[$];
  int   pend[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   m_state = 0;
  int   m_good = 0;
  int   last_tick = 0;
  int   m_level = 0;
  int   m_run = 0;
  int   last_seen = -1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2 pps_in = v;
    end
  endtask

  task automatic pulse(input int w, input int period);
    drive(1'b1, w);
    drive(1'b0, period - w);
  endtask

  task automatic reset_for(input int n);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Reference: elapsed time since last tick decides every edge and timeout
  initial begin
    int  el;
    bit  has_edge;
    bit  tick;
    int  mis;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        last_tick = cyc;
        m_state   = 0;
        m_good    = 0;
        m_level   = 0;
        m_run     = 0;
        pend.delete();
      end else begin
        el       = cyc - last_tick - 1;
        has_edge = (pend.size() > 0) && (pend[0] == cyc);
        if (has_edge) void'(pend.pop_front());
        tick = 1'b0;
        mis  = 0;
        if (m_state == 0 || m_state == 3) begin
          if (has_edge) begin
            tick      = (el >= CLK_DIV / 2);
            last_tick = cyc;
            m_state   = 1;
            m_good    = 0;
          end else if (el == CLK_DIV - 1) begin
            tick      = 1'b1;
            last_tick = cyc;
          end
        end else begin
          if (has_edge && el >= CLK_DIV - 1 - TOL) begin
            tick      = 1'b1;
            last_tick = cyc;
            if (m_state == 1) begin
              m_good++;
              if (m_good == LOCK_COUNT) m_state = 2;
            end
          end else if (has_edge) begin
            m_good  = 0;
            m_state = 1;
          end else if (el == CLK_DIV - 1 + TOL) begin
            tick      = 1'b1;
            mis       = 1;
            last_tick = cyc;
            m_good    = 0;
            m_state   = (m_state == 1) ? 0 : 3;
          end
        end
        if (tick) expq.push_back('{cyc, mis});
        // Filtered rising edge reaches the state machine FILT+3 cycles after the first high sample
        if (int'(pps_in) == m_level) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == FILT) begin
            m_level = int'(pps_in);
            m_run   = 0;
            if (m_level == 1) pend.push_back(cyc + 4);
          end
        end
      end
    end
  end

  // Monitor: compare registered outputs between clock edges
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_tick", int'(sec_tick), 0);
        check("reset_miss", int'(miss), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_state", int'(state), 0);
        expq.delete();
        last_seen = -1;
      end else begin
        check("state", int'(state), m_state);
        check("locked", int'(locked), int'(m_state == 2));
        if (sec_tick) begin
          if (expq.size() == 0) begin
            check("tick_unexpected", int'(sec_tick), 0);
          end else begin
            e = expq.pop_front();
            check("tick_cycle", cyc, e.cyc);
            check("tick_miss", int'(miss), e.mis);
          end
          if (last_seen >= 0) check("tick_spacing", int'(cyc - last_seen >= CLK_DIV / 2), 1);
          last_seen = cyc;
        end else begin
          check("idle_miss", int'(miss), 0);
          if (expq.size() > 0 && expq[0].cyc <= cyc) begin
            check("tick_present", int'(sec_tick), 1);
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int iv[10] = '{98, 102, 99, 101, 100, 97, 100, 100, 100, 100};
    int r;
    int w;
    int p;
    rst    = 1'b1;
    pps_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Free-running with no reference
    drive(1'b0, 350);

    // Acquire and lock on a nominal reference
    reset_for(2);
    drive(1'b0, 40);
    repeat (6) pulse(10, 100);

    // Reference lost while locked
    drive(1'b0, 350);

    // Relock, then a glitch and an early pulse
    repeat (6) pulse(10, 100);
    pulse(10, 50);
    pulse(1, 6);
    pulse(10, 44);
    repeat (4) pulse(10, 100);

    // Window boundaries
    foreach (iv[i]) pulse(10, iv[i]);

    // Reset while locked with an edge in flight
    repeat (5) pulse(10, 100);
    drive(1'b1, 4);
    @(posedge clk);
    #2;
    pps_in = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    drive(1'b0, 250);

    // Randomized reference behaviour
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        p = int'($urandom_range(96, 104));
        w = int'($urandom_range(1, 12));
        pulse(w, p);
      end else if (r == 6) begin
        pulse(int'($urandom_range(1, FILT)), int'($urandom_range(5, 30)));
      end else if (r == 7) begin
        drive(1'b0, int'($urandom_range(150, 300)));
      end else if (r == 8) begin
        reset_for(int'($urandom_range(1, 3)));
        drive(1'b0, int'($urandom_range(10, 60)));
      end else begin
        pulse(int'($urandom_range(3, 10)), int'($urandom_range(20, 80)));
      end
    end

    drive(1'b0, 150);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
